// File: rtl/power_dvfs_ctrl.sv
// rtl/power_dvfs_ctrl.sv - DVFS sequencer with settle timers, power gating and optional thermal throttle (DVFS_THERMAL_THROTTLE_EN)
module power_dvfs_ctrl #(
    parameter int MAX_LEVEL   = 7,
    parameter int RESET_LEVEL = 4,
    parameter int THROT_LEVEL = 2,
    parameter int V_SETTLE    = 16,
    parameter int F_SETTLE    = 4,
    parameter logic [15:0] TEMP_HI = 16'h0C80,
    parameter logic [15:0] TEMP_LO = 16'h0B40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dvfs_req,
    input  logic [3:0]  req_level,
    input  logic        gate_req,
    input  logic [15:0] temp_sensor,
    input  logic        thermal_alert,
    output logic [3:0]  voltage_level,
    output logic [7:0]  freq_divider,
    output logic        clock_gate_en,
    output logic        power_gate_en,
    output logic        dvfs_ack,
    output logic        busy,
    output logic        throttled
);

    localparam logic [3:0]  MAX_L    = 4'(MAX_LEVEL);
    localparam logic [3:0]  RST_L    = 4'(RESET_LEVEL);
    localparam logic [3:0]  THR_L    = 4'(THROT_LEVEL);
    localparam logic [7:0]  FD_BASE  = 8'(MAX_LEVEL + 1);
    localparam logic [7:0]  FD_RESET = 8'(MAX_LEVEL + 1 - RESET_LEVEL);
    localparam logic [15:0] V_CNT    = 16'(V_SETTLE - 1);
    localparam logic [15:0] F_CNT    = 16'(F_SETTLE - 1);

    typedef enum logic [3:0] {
        IDLE, V_UP, F_UP, F_DN, V_DN, ACK, GATE_C, GATE_P, UNGATE
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  tgt;
    logic [3:0]  tgt_q;
    logic        auto_tx;

`ifdef DVFS_THERMAL_THROTTLE_EN
    // Hysteretic throttle flag: set hot, clear only once cool, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            throttled <= 1'b0;
        end else if (thermal_alert || (temp_sensor >= TEMP_HI)) begin
            throttled <= 1'b1;
        end else if (temp_sensor < TEMP_LO) begin
            throttled <= 1'b0;
        end
    end
`else
    logic unused_thermal;
    assign unused_thermal = ^{temp_sensor, thermal_alert, TEMP_HI, TEMP_LO};
    assign throttled      = 1'b0;
`endif

    // Effective target: clamp to the legal range, then to the thermal ceiling
    always_comb begin
        tgt = (req_level > MAX_L) ? MAX_L : req_level;
`ifdef DVFS_THERMAL_THROTTLE_EN
        if (throttled && (tgt > THR_L)) begin
            tgt = THR_L;
        end
`endif
    end

    assign busy = (state != IDLE);

    // Sequencer: voltage leads frequency going up, frequency leads voltage going down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            tgt_q         <= RST_L;
            auto_tx       <= 1'b0;
            voltage_level <= RST_L;
            freq_divider  <= FD_RESET;
            clock_gate_en <= 1'b0;
            power_gate_en <= 1'b0;
            dvfs_ack      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
`ifdef DVFS_THERMAL_THROTTLE_EN
                    if (throttled && (voltage_level > THR_L)) begin
                        auto_tx       <= 1'b1;
                        tgt_q         <= THR_L;
                        freq_divider  <= FD_BASE - {4'd0, THR_L};
                        clock_gate_en <= 1'b1;
                        cnt           <= F_CNT;
                        state         <= F_DN;
                    end else
`endif
                    if (dvfs_req) begin
                        auto_tx <= 1'b0;
                        tgt_q   <= tgt;
                        if (tgt > voltage_level) begin
                            voltage_level <= tgt;
                            cnt           <= V_CNT;
                            state         <= V_UP;
                        end else if (tgt < voltage_level) begin
                            freq_divider  <= FD_BASE - {4'd0, tgt};
                            clock_gate_en <= 1'b1;
                            cnt           <= F_CNT;
                            state         <= F_DN;
                        end else begin
                            state <= ACK;
                        end
                    end else if (gate_req) begin
                        clock_gate_en <= 1'b1;
                        state         <= GATE_C;
                    end
                end
                V_UP: begin
                    if (cnt == '0) begin
                        freq_divider  <= FD_BASE - {4'd0, tgt_q};
                        clock_gate_en <= 1'b1;
                        cnt           <= F_CNT;
                        state         <= F_UP;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                F_UP: begin
                    if (cnt == '0) begin
                        clock_gate_en <= 1'b0;
                        dvfs_ack      <= 1'b1;
                        state         <= ACK;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                F_DN: begin
                    if (cnt == '0) begin
                        clock_gate_en <= 1'b0;
                        voltage_level <= tgt_q;
                        cnt           <= V_CNT;
                        state         <= V_DN;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                V_DN: begin
                    if (cnt == '0) begin
                        if (auto_tx) begin
                            auto_tx <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            dvfs_ack <= 1'b1;
                            state    <= ACK;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ACK: begin
                    // Equal-level entry arrives with ack low; raise it once so every request sees a pulse
                    if (!dvfs_ack) begin
                        dvfs_ack <= 1'b1;
                    end else if (!dvfs_req) begin
                        dvfs_ack <= 1'b0;
                        state    <= IDLE;
                    end
                end
                GATE_C: begin
                    power_gate_en <= 1'b1;
                    state         <= GATE_P;
                end
                GATE_P: begin
                    if (!gate_req) begin
                        power_gate_en <= 1'b0;
                        cnt           <= V_CNT;
                        state         <= UNGATE;
                    end
                end
                UNGATE: begin
                    if (cnt == '0) begin
                        clock_gate_en <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
